// File: rtl/sweep_instr_assembler.sv
// -----------------------------------------------------------------------------
// sweep_instr_assembler
//
// Builds 88-bit sweep/PLL instruction words from a framed host byte stream and
// writes them into the instruction FIFO drained by the frequency sweeper.
// A frame starts with SYNC_BYTE and carries 11 payload bytes, MSB first.
// With the optional checksum feature (macro INSTR_CHECKSUM_EN), an XOR
// checksum byte follows the payload. Only good frames are pushed. Frames that
// fail the checksum or stall for too long are dropped and counted.
//
// Build option:
//   INSTR_CHECKSUM_EN  defined   -> sync + 11 payload + 1 XOR byte, CHECK state
//                      undefined -> sync + 11 payload, timeout is the only error
//
// Ports:
//   clk           system clock (50 MHz)
//   reset         asynchronous, active-high reset
//   rx_data       byte from the host receiver
//   rx_valid      rx_data valid
//   rx_ready      byte accepted on an edge where rx_valid && rx_ready
//   fifo_wr_data  instruction: [87] mode, [86:80] reserved (0), [79:48]
//                 init_freq, [47:32] cycles_per_step, [31:0] freq_step
//   fifo_wr_en    single-cycle FIFO write strobe
//   fifo_full     FIFO full flag
//   frame_ok      one-cycle pulse together with fifo_wr_en
//   frame_err     one-cycle pulse on checksum mismatch or timeout
//   err_count     saturating count of dropped frames
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sweep_instr_assembler #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [87:0] fifo_wr_data,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [7:0]  err_count
);

    // Idle counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int                 CNT_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   IDLE_ONE  = CNT_W'(1);

`ifdef INSTR_CHECKSUM_EN
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        PUSH    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        PUSH    = 2'd3
    } state_t;
`endif

    state_t           state_reg, state_next;
    logic [87:0]      shift_reg, shift_next;
    logic [3:0]       idx_reg, idx_next;
    logic [CNT_W-1:0] idle_reg, idle_next;
    logic [87:0]      wr_data_reg, wr_data_next;
    logic             wr_en_reg, wr_en_next;
    logic             ok_reg, ok_next;
    logic             err_reg, err_next;
    logic [7:0]       err_cnt_reg, err_cnt_next;
`ifdef INSTR_CHECKSUM_EN
    logic [7:0]       csum_reg, csum_next;
`endif

    logic accept;
    logic in_frame;
    logic drop;

    assign rx_ready = (state_reg != PUSH);
    assign accept   = rx_valid && rx_ready;

`ifdef INSTR_CHECKSUM_EN
    assign in_frame = (state_reg == PAYLOAD) || (state_reg == CHECK);
`else
    assign in_frame = (state_reg == PAYLOAD);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= HUNT;
            shift_reg   <= '0;
            idx_reg     <= '0;
            idle_reg    <= '0;
            wr_data_reg <= '0;
            wr_en_reg   <= 1'b0;
            ok_reg      <= 1'b0;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
`ifdef INSTR_CHECKSUM_EN
            csum_reg    <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            idx_reg     <= idx_next;
            idle_reg    <= idle_next;
            wr_data_reg <= wr_data_next;
            wr_en_reg   <= wr_en_next;
            ok_reg      <= ok_next;
            err_reg     <= err_next;
            err_cnt_reg <= err_cnt_next;
`ifdef INSTR_CHECKSUM_EN
            csum_reg    <= csum_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        idx_next     = idx_reg;
        idle_next    = idle_reg;
        wr_data_next = wr_data_reg;
        wr_en_next   = 1'b0;
        ok_next      = 1'b0;
        err_next     = 1'b0;
        err_cnt_next = err_cnt_reg;
        drop         = 1'b0;
`ifdef INSTR_CHECKSUM_EN
        csum_next    = csum_reg;
`endif

        case (state_reg)
            HUNT: begin
                // Non-sync bytes are discarded silently.
                if (accept && (rx_data == SYNC_BYTE)) begin
                    idx_next   = '0;
                    idle_next  = '0;
`ifdef INSTR_CHECKSUM_EN
                    csum_next  = '0;
`endif
                    state_next = PAYLOAD;
                end
            end

            PAYLOAD: begin
                // SYNC_BYTE inside a frame is plain data: no resync here.
                if (accept) begin
                    shift_next = {shift_reg[79:0], rx_data};
                    idle_next  = '0;
`ifdef INSTR_CHECKSUM_EN
                    csum_next  = csum_reg ^ rx_data;
`endif
                    if (idx_reg == 4'd10) begin
`ifdef INSTR_CHECKSUM_EN
                        state_next = CHECK;
`else
                        state_next = PUSH;
`endif
                    end else begin
                        idx_next = idx_reg + 4'd1;
                    end
                end
            end

`ifdef INSTR_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    idle_next = '0;
                    if (rx_data == csum_reg) begin
                        state_next = PUSH;
                    end else begin
                        drop       = 1'b1;
                        state_next = HUNT;
                    end
                end
            end
`endif

            PUSH: begin
                // No timeout here: wait as long as the FIFO stays full.
                if (!fifo_full) begin
                    wr_data_next = {shift_reg[87], 7'b0, shift_reg[79:0]};
                    wr_en_next   = 1'b1;
                    ok_next      = 1'b1;
                    state_next   = HUNT;
                end
            end

            default: begin
                state_next = HUNT;
            end
        endcase

        // Idle timeout inside a frame. An accepted byte on the same edge wins.
        if (in_frame && !accept) begin
            if (idle_reg == IDLE_LAST) begin
                drop       = 1'b1;
                state_next = HUNT;
            end else begin
                idle_next = idle_reg + IDLE_ONE;
            end
        end

        if (drop) begin
            err_next = 1'b1;
            if (err_cnt_reg != 8'hFF) begin
                err_cnt_next = err_cnt_reg + 8'd1;
            end
        end
    end

    assign fifo_wr_data = wr_data_reg;
    assign fifo_wr_en   = wr_en_reg;
    assign frame_ok     = ok_reg;
    assign frame_err    = err_reg;
    assign err_count    = err_cnt_reg;

endmodule

// File: tb/tb_sweep_instr_assembler.sv
`timescale 1ns/1ps

module tb_sweep_instr_assembler;

    localparam int TO = 100;
`ifdef INSTR_CHECKSUM_EN
    localparam int FRAME_LEN = 13;
`else
    localparam int FRAME_LEN = 12;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [87:0] fifo_wr_data;
    logic        fifo_wr_en;
    logic        fifo_full = 1'b0;
    logic        frame_ok;
    logic        frame_err;
    logic [7:0]  err_count;

    int tests_run = 0;
    int tests_failed = 0;
    int err_pulses = 0;
    int cyc = 0;
    logic mon_en = 1'b0;
    logic [87:0] push_q[$];

    sweep_instr_assembler #(
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .fifo_wr_data(fifo_wr_data),
        .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full),
        .frame_ok(frame_ok),
        .frame_err(frame_err),
        .err_count(err_count)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: logs pushes and error pulses, checks pulse pairing.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (fifo_wr_en === 1'b1) begin
                push_q.push_back(fifo_wr_data);
                $display("[TB] push data=%h err_count=%0d", fifo_wr_data, err_count);
            end
            if (frame_err === 1'b1) err_pulses = err_pulses + 1;
            if (fifo_wr_en === 1'b1 || frame_ok === 1'b1 || frame_err === 1'b1) begin
                tests_run = tests_run + 1;
                if (frame_ok !== fifo_wr_en || (frame_ok === 1'b1 && frame_err === 1'b1)) begin
                    tests_failed = tests_failed + 1;
                    $display("FAIL pulse_pairing: wr_en=%b frame_ok=%b frame_err=%b", fifo_wr_en, frame_ok, frame_err);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Present one byte and hold it until accepted (bounded).
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (rx_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_byte_stall: rx_ready=%b required 1 within 1000 cycles", rx_ready);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame_ck(input logic [87:0] p, input logic [7:0] ck);
        send_byte(8'hA5);
        for (int i = 0; i < 11; i++) send_byte(p[87-8*i -: 8]);
`ifdef INSTR_CHECKSUM_EN
        send_byte(ck);
        $display("[TB] frame sent payload=%h ck=%h", p, ck);
`else
        $display("[TB] frame sent payload=%h (ck %h unused)", p, ck);
`endif
    endtask

    function automatic logic [7:0] xor_of(input logic [87:0] p);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 11; i++) c = c ^ p[87-8*i -: 8];
        return c;
    endfunction

    task automatic send_frame(input logic [87:0] p);
        send_frame_ck(p, xor_of(p));
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        #4;
        tests_run++;
        if (rx_ready !== 1'b1 || fifo_wr_en !== 1'b0 || frame_ok !== 1'b0 || frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: rx_ready=%b wr_en=%b ok=%b err=%b required 1 0 0 0", rx_ready, fifo_wr_en, frame_ok, frame_err);
        end
        tests_run++;
        if (err_count !== 8'h00 || fifo_wr_data !== 88'h0) begin
            tests_failed++;
            $display("FAIL reset_data: err_count=%h data=%h required 00 0", err_count, fifo_wr_data);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_good_frame;
        logic [87:0] p;
        int base;
        p = 88'h80_00100000_0064_00000100;
        base = push_q.size();
        send_frame(p);
        @(negedge clk);
        tests_run++;
        if (rx_ready !== 1'b0 || fifo_wr_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL good_push_state: rx_ready=%b wr_en=%b required 0 0", rx_ready, fifo_wr_en);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (fifo_wr_en !== 1'b1 || frame_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL good_latency: wr_en=%b ok=%b required 1 1", fifo_wr_en, frame_ok);
        end
        tests_run++;
        if (fifo_wr_data !== 88'h80_00100000_0064_00000100) begin
            tests_failed++;
            $display("FAIL good_data: got %h required %h", fifo_wr_data, 88'h80_00100000_0064_00000100);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (push_q.size() != base + 1 || err_count !== 8'h00) begin
            tests_failed++;
            $display("FAIL good_count: pushes=%0d err_count=%0d required %0d 0", push_q.size() - base, err_count, 1);
        end
    endtask

`ifdef INSTR_CHECKSUM_EN
    task automatic test_bad_checksum;
        logic [87:0] p;
        int base;
        logic [7:0] e0;
        p = 88'h80_00100000_0064_00000100;
        base = push_q.size();
        e0 = err_count;
        send_frame_ck(p, 8'hF4);
        tests_run++;
        if (frame_err !== 1'b1 || err_count !== e0 + 8'd1) begin
            tests_failed++;
            $display("FAIL bad_ck_err: frame_err=%b err_count=%0d required 1 %0d", frame_err, err_count, e0 + 8'd1);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (push_q.size() != base) begin
            tests_failed++;
            $display("FAIL bad_ck_nopush: pushes=%0d required 0", push_q.size() - base);
        end
        send_frame(p);
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (push_q.size() != base + 1 || push_q[$] !== p) begin
            tests_failed++;
            $display("FAIL bad_ck_recover: pushes=%0d data=%h required 1 %h", push_q.size() - base, push_q[$], p);
        end
    endtask
`endif

    task automatic test_garbage_and_sync_data;
        int base;
        base = push_q.size();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        send_frame(88'h80_00100000_0064_00000100);
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (push_q.size() != base + 1 || push_q[$] !== 88'h80_00100000_0064_00000100) begin
            tests_failed++;
            $display("FAIL garbage_skip: pushes=%0d data=%h required 1 %h", push_q.size() - base, push_q[$], 88'h80_00100000_0064_00000100);
        end
        // byte 3 = A5 is data; byte 0 = 01 so bit 80 must be cleared.
        send_frame(88'h01_2345A567_89AB_CDEF0102);
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (push_q.size() != base + 2 || push_q[$] !== 88'h00_2345A567_89AB_CDEF0102) begin
            tests_failed++;
            $display("FAIL sync_in_payload: pushes=%0d data=%h required 2 %h", push_q.size() - base, push_q[$], 88'h00_2345A567_89AB_CDEF0102);
        end
    endtask

    task automatic test_timeout;
        logic [87:0] p;
        int base;
        int ep;
        logic [7:0] e0;
        p = 88'h80_00000001_0002_00000003;
        base = push_q.size();
        e0 = err_count;
        ep = err_pulses;
        send_byte(8'hA5);
        for (int i = 0; i < 5; i++) send_byte(p[87-8*i -: 8]);
        repeat (99) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_early: frame_err=%b after 99 idle cycles required 0", frame_err);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (frame_err !== 1'b1 || err_count !== e0 + 8'd1 || rx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_fire: frame_err=%b err_count=%0d rx_ready=%b required 1 %0d 1", frame_err, err_count, rx_ready, e0 + 8'd1);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_pulse_width: frame_err=%b required 0", frame_err);
        end
        // Gaps of 98 and 99 idle cycles must not time out.
        ep = err_pulses;
        send_byte(8'hA5);
        for (int i = 0; i < 5; i++) send_byte(p[87-8*i -: 8]);
        repeat (98) @(posedge clk);
        #1;
        for (int i = 5; i < 8; i++) send_byte(p[87-8*i -: 8]);
        repeat (99) @(posedge clk);
        #1;
        for (int i = 8; i < 11; i++) send_byte(p[87-8*i -: 8]);
`ifdef INSTR_CHECKSUM_EN
        send_byte(xor_of(p));
`endif
        $display("[TB] gapped frame sent payload=%h", p);
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (push_q.size() != base + 1 || push_q[$] !== p || err_pulses != ep) begin
            tests_failed++;
            $display("FAIL timeout_gap: pushes=%0d data=%h errs=%0d required 1 %h 0", push_q.size() - base, push_q[$], err_pulses - ep, p);
        end
    endtask

    task automatic test_backpressure;
        int base;
        int bad;
        base = push_q.size();
        bad = 0;
        fifo_full = 1'b1;
        send_frame(88'hFF_12345678_9ABC_DEF01234);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_ready !== 1'b0 || fifo_wr_en !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bp_hold: %0d cycles with rx_ready/wr_en high required 0", bad);
        end
        @(posedge clk);
        #1 fifo_full = 1'b0;
        @(negedge clk);
        tests_run++;
        if (fifo_wr_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release_early: wr_en=%b required 0", fifo_wr_en);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 88'h80_12345678_9ABC_DEF01234) begin
            tests_failed++;
            $display("FAIL bp_push: wr_en=%b data=%h required 1 %h", fifo_wr_en, fifo_wr_data, 88'h80_12345678_9ABC_DEF01234);
        end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (push_q.size() != base + 1 || fifo_wr_data !== 88'h80_12345678_9ABC_DEF01234) begin
            tests_failed++;
            $display("FAIL bp_single: pushes=%0d data=%h required 1 held", push_q.size() - base, fifo_wr_data);
        end
    endtask

    task automatic test_back_to_back;
        int base;
        int c0;
        base = push_q.size();
        c0 = cyc;
        send_frame(88'h80_00000010_0020_00000030);
        send_frame(88'h00_AAAAAAAA_BBBB_CCCCCCCC);
        tests_run++;
        if (cyc != c0 + 2 * FRAME_LEN + 1) begin
            tests_failed++;
            $display("FAIL b2b_rate: cycles=%0d required %0d", cyc - c0, 2 * FRAME_LEN + 1);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (push_q.size() != base + 2 || push_q[base] !== 88'h80_00000010_0020_00000030 || push_q[base+1] !== 88'h00_AAAAAAAA_BBBB_CCCCCCCC) begin
            tests_failed++;
            $display("FAIL b2b_data: pushes=%0d last=%h required 2 %h", push_q.size() - base, push_q[$], 88'h00_AAAAAAAA_BBBB_CCCCCCCC);
        end
    endtask

    task automatic test_reset_midframe;
        int base;
        send_byte(8'hA5);
        for (int i = 0; i < 6; i++) send_byte(8'h11 * (i + 1));
        #4 reset = 1'b1;
        #1;
        tests_run++;
        if (rx_ready !== 1'b1 || fifo_wr_en !== 1'b0 || frame_err !== 1'b0 || err_count !== 8'h00 || fifo_wr_data !== 88'h0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: rx_ready=%b wr_en=%b err=%b err_count=%h data=%h required 1 0 0 00 0", rx_ready, fifo_wr_en, frame_err, err_count, fifo_wr_data);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        base = push_q.size();
        send_frame(88'h80_CAFEBABE_1234_0BADF00D);
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (push_q.size() != base + 1 || push_q[$] !== 88'h80_CAFEBABE_1234_0BADF00D || err_count !== 8'h00) begin
            tests_failed++;
            $display("FAIL midreset_frame: pushes=%0d data=%h err_count=%0d required 1 %h 0", push_q.size() - base, push_q[$], err_count, 88'h80_CAFEBABE_1234_0BADF00D);
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 254; i++) begin
            send_byte(8'hA5);
            repeat (TO) @(posedge clk);
            #1;
        end
        tests_run++;
        if (err_count !== 8'hFE) begin
            tests_failed++;
            $display("FAIL sat_fe: err_count=%h required FE", err_count);
        end
        for (int i = 0; i < 46; i++) begin
            send_byte(8'hA5);
            repeat (TO) @(posedge clk);
            #1;
        end
        $display("[TB] 300 stalled frames sent");
        tests_run++;
        if (err_count !== 8'hFF) begin
            tests_failed++;
            $display("FAIL sat_ff: err_count=%h required FF", err_count);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
`ifdef INSTR_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_garbage_and_sync_data();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_midframe();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sweep_instr_assembler.md
# sweep_instr_assembler

Assembles framed byte-stream instructions from the host link into 88-bit sweep/PLL instruction words and writes them into the instruction FIFO that the frequency sweeper drains. The block sits between the host byte receiver and the 88-bit instruction FIFO. It hunts for a sync byte, collects 11 payload bytes MSB-first, and optionally verifies a checksum. Only good frames are pushed; bad or stalled frames are dropped and counted.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT_CYCLES, 50000, maximum idle cycles between bytes inside a frame (1 ms at 50 MHz); minimum 2
- clk  input  1  50 MHz system clock
- reset  input  1  asynchronous, active-high reset
- rx_data  input  8  byte from the host receiver
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  block can accept a byte; a byte transfers on a rising edge where rx_valid && rx_ready
- fifo_wr_data  output  88  assembled instruction: [87] mode (0 sweep, 1 PLL), [86:80] reserved, [79:48] init_freq, [47:32] cycles_per_step, [31:0] freq_step
- fifo_wr_en  output  1  single-cycle write strobe to the instruction FIFO
- fifo_full  input  1  FIFO full flag
- frame_ok  output  1  one-cycle pulse, coincident with fifo_wr_en
- frame_err  output  1  one-cycle pulse on checksum mismatch or timeout
- err_count  output  8  saturating count of dropped frames

## Operation
- States: HUNT, PAYLOAD, CHECK (present only with the checksum feature), PUSH.
- HUNT: accepted bytes not equal to SYNC_BYTE are discarded silently. On SYNC_BYTE: clear the byte index and the running XOR, then go to PAYLOAD.
- PAYLOAD: each accepted byte shifts into a shift register MSB-first, byte 0 landing in [87:80], and is XORed into the running checksum. The index counts 0..10.
  - After byte 10: go to CHECK when the checksum feature is compiled in, otherwise go to PUSH.
- Within a frame, a byte equal to SYNC_BYTE is ordinary data; no resync occurs.
- CHECK: the next accepted byte is compared with the running XOR.
  - Equal: go to PUSH.
  - Not equal: pulse frame_err, increment err_count, go to HUNT.
- PUSH: rx_ready is low. On any cycle with fifo_full low: register fifo_wr_data, with [86:80] forced to 0; pulse fifo_wr_en and frame_ok; go to HUNT. While fifo_full is high the block waits indefinitely; no timeout applies.
- Timeout: an idle counter runs in PAYLOAD and CHECK and clears on every accepted byte. When it reaches TIMEOUT_CYCLES-1: pulse frame_err, increment err_count, go to HUNT, and discard the partial frame.
- err_count saturates at 8'hFF and is cleared only by reset.
- rx_ready is decoded from the state: high in HUNT, PAYLOAD and CHECK; low in PUSH.
- Reset (asynchronous, any state, including mid-frame): state HUNT; fifo_wr_en, frame_ok, frame_err = 0; err_count = 0; fifo_wr_data = 0; rx_ready = 1. Any partial frame is lost.

## Timing
- One byte is accepted per cycle at most; back-to-back bytes are accepted at full rate.
- Latency: the final frame byte is accepted at edge N. The state is PUSH after edge N. With fifo_full low, fifo_wr_en is high for the cycle following edge N+1.
- fifo_full is sampled in the cycle before the write strobe. This is safe because this block is the FIFO's only writer.
- fifo_wr_data is stable from the edge that asserts fifo_wr_en until the next push.
- A byte presented during the fifo_wr_en cycle (state HUNT) is accepted. Back-to-back frames therefore need 1 non-ready cycle per frame.
- A timeout and a byte arriving on the same edge: the byte wins, and the counter clears.
- frame_err and frame_ok are never asserted together.

## Configuration
- INSTR_CHECKSUM_EN defined:
  - The frame is sync + 11 payload bytes + 1 XOR checksum byte (13 bytes).
  - CHECK state is present.
  - Mismatch drops the frame.
- INSTR_CHECKSUM_EN undefined:
  - The frame is sync + 11 payload bytes (12 bytes).
  - CHECK state and XOR logic are removed.
  - The only error source is timeout.

## Test plan
- Good frame (INSTR_CHECKSUM_EN defined): A5, 80 00 10 00 00 00 64 00 00 01 00, F5 -> one fifo_wr_en, fifo_wr_data = 88'h80_00100000_0064_00000100, frame_ok, err_count stays 0.
- Same frame with checksum F4 -> no fifo_wr_en, one frame_err, err_count = 1. A following good frame is pushed normally.
- Garbage 00 FF 12 before A5 plus a good frame -> the leading bytes are ignored, exactly one push. A frame with payload byte 3 = A5 and a correct checksum is pushed intact.
- Timeout (TIMEOUT_CYCLES=100): send A5 + 5 bytes, then idle for 100 cycles -> frame_err, HUNT, no push. A gap of 98 cycles between bytes -> frame completes and is pushed.
- FIFO backpressure: fifo_full held high for 20 cycles when the frame completes -> rx_ready low and no write during the hold; fifo_wr_en pulses 2 cycles after fifo_full falls; reserved bits [86:80] = 0 even if byte 0 = FF.
- Reset mid-frame after 6 payload bytes, then a good frame -> outputs at reset values during reset; exactly one push with the new frame's data. 300 bad frames -> err_count = FF (saturated).
